// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU control codes, base opcodes and the decoded issue entry.
package cpu_pkg;

  localparam logic [3:0] CNTL_ADD  = 4'b0000;
  localparam logic [3:0] CNTL_SLT  = 4'b0001;
  localparam logic [3:0] CNTL_SLTU = 4'b0010;
  localparam logic [3:0] CNTL_AND  = 4'b0011;
  localparam logic [3:0] CNTL_OR   = 4'b0100;
  localparam logic [3:0] CNTL_XOR  = 4'b0101;
  localparam logic [3:0] CNTL_SLL  = 4'b0110;
  localparam logic [3:0] CNTL_SRL  = 4'b0111;
  localparam logic [3:0] CNTL_SUB  = 4'b1000;
  localparam logic [3:0] CNTL_SRA  = 4'b1001;
  localparam logic [3:0] CNTL_AM   = 4'b1010;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  typedef struct packed {
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [3:0]  cntl;
    logic        not_s;
    logic        is_branch;
    logic [2:0]  br_f3;
    logic        illegal;
  } issue_t;

  // Value presented on the outputs while in reset: zero operands, ADD, signed.
  localparam issue_t ISSUE_RESET = '{
    srca: '0, srcb: '0, cntl: CNTL_ADD, not_s: 1'b1,
    is_branch: 1'b0, br_f3: '0, illegal: 1'b0
  };

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  // instr[30] means SUB only for register-register ADD; it always means SRA for funct3 101.
  function automatic logic [3:0] f3_to_cntl(input logic [2:0] f3, input logic alt,
                                            input logic reg_form);
    logic [3:0] c;
    case (f3)
      3'b000:  c = (alt && reg_form) ? CNTL_SUB : CNTL_ADD;
      3'b001:  c = CNTL_SLL;
      3'b010:  c = CNTL_SLT;
      3'b011:  c = CNTL_SLTU;
      3'b100:  c = CNTL_XOR;
      3'b101:  c = alt ? CNTL_SRA : CNTL_SRL;
      3'b110:  c = CNTL_OR;
      default: c = CNTL_AND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational decode of an RV32 word into ALU operands and control for alu_issue.
module alu_issue_dec
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output issue_t      dec
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [31:0] imm_i;
  logic        unused_fields;

  assign opcode        = instr[6:0];
  assign f3            = instr[14:12];
  assign imm_i         = {{20{instr[31]}}, instr[31:20]};
  assign unused_fields = ^{instr[19:15], instr[11:7]};

  always_comb begin
    dec         = ISSUE_RESET;
    dec.illegal = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec.illegal = 1'b0;
        dec.srca    = rs1;
        dec.srcb    = rs2;
        dec.cntl    = f3_to_cntl(f3, instr[30], 1'b1);
        dec.not_s   = (f3 != 3'b011);
      end
      OPC_OP_IMM: begin
        dec.illegal = 1'b0;
        dec.srca    = rs1;
        dec.srcb    = imm_i;
        dec.cntl    = f3_to_cntl(f3, instr[30], 1'b0);
        dec.not_s   = (f3 != 3'b011);
      end
      OPC_BRANCH: begin
        if (f3[2:1] != 2'b01) begin
          dec.illegal   = 1'b0;
          dec.srca      = rs1;
          dec.srcb      = rs2;
          dec.is_branch = 1'b1;
          dec.br_f3     = f3;
          case (f3[2:1])
            2'b00:   dec.cntl = CNTL_SUB;
            2'b10:   dec.cntl = CNTL_SLT;
            default: dec.cntl = CNTL_SLTU;
          endcase
          dec.not_s = (f3[2:1] != 2'b11);
        end
      end
      OPC_CUSTOM0: begin
        if (f3 == 3'b000) begin
          dec.illegal = 1'b0;
          dec.srca    = rs1;
          dec.srcb    = rs2;
          dec.cntl    = CNTL_AM;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes one instruction per transfer into a 2-entry skid buffer.
module alu_issue
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_srca,
  output logic [31:0] out_srcb,
  output logic [3:0]  out_cntl,
  output logic        out_not_s,
  output logic        out_is_branch,
  output logic [2:0]  out_br_f3,
  output logic        out_illegal
);

  issue_t     dec;
  issue_t     head_q, head_d;
  issue_t     tail_q, tail_d;
  buf_state_t state_q, state_d;
  logic       push, pop;

  alu_issue_dec u_dec (
    .instr (in_instr),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .dec   (dec)
  );

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready;

  // head always drives the outputs; tail only holds the second entry when full.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (push) begin
            head_d  = dec;
            state_d = BUF_ONE;
          end
        end
        BUF_ONE: begin
          case ({push, pop})
            2'b11: head_d = dec;
            2'b10: begin
              tail_d  = dec;
              state_d = BUF_FULL;
            end
            2'b01: state_d = BUF_EMPTY;
            default: ;
          endcase
        end
        BUF_FULL: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = BUF_ONE;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BUF_EMPTY;
      head_q    <= ISSUE_RESET;
      tail_q    <= ISSUE_RESET;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      out_valid <= (state_d != BUF_EMPTY);
      in_ready  <= (state_d != BUF_FULL);
    end
  end

  assign out_srca      = head_q.srca;
  assign out_srcb      = head_q.srcb;
  assign out_cntl      = head_q.cntl;
  assign out_not_s     = head_q.not_s;
  assign out_is_branch = head_q.is_branch;
  assign out_br_f3     = head_q.br_f3;
  assign out_illegal   = head_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed decode vectors, backpressure, flush and reset.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_srca;
  logic [31:0] out_srcb;
  logic [3:0]  out_cntl;
  logic        out_not_s;
  logic        out_is_branch;
  logic [2:0]  out_br_f3;
  logic        out_illegal;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [73:0] exp;
  } vec_t;

  vec_t vecs[$];
  vec_t expq[$];
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_srca      (out_srca),
    .out_srcb      (out_srcb),
    .out_cntl      (out_cntl),
    .out_not_s     (out_not_s),
    .out_is_branch (out_is_branch),
    .out_br_f3     (out_br_f3),
    .out_illegal   (out_illegal)
  );

  function automatic logic [73:0] mk(input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] c, input logic ns, input logic br,
                                     input logic [2:0] f3, input logic ill);
    return {a, b, c, ns, br, f3, ill};
  endfunction

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_op(input logic [11:0] imm, input logic [2:0] f3);
    return {imm, 5'd1, f3, 5'd3, 7'b0010011};
  endfunction

  function automatic logic [31:0] b_op(input logic [2:0] f3);
    return {7'd0, 5'd2, 5'd1, f3, 5'd0, 7'b1100011};
  endfunction

  function automatic logic [31:0] c0_op(input logic [2:0] f3);
    return {7'd0, 5'd2, 5'd1, f3, 5'd3, 7'b0001011};
  endfunction

  task automatic add(input logic [31:0] instr, input logic [31:0] rs1,
                     input logic [31:0] rs2, input logic [73:0] exp);
    vec_t v;
    v.instr = instr; v.rs1 = rs1; v.rs2 = rs2; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Drive one entry until accepted; the expected result is queued at acceptance.
  task automatic send(input vec_t v);
    bit acc = 0;
    int n = 0;
    in_valid = 1'b1;
    in_instr = v.instr;
    in_rs1   = v.rs1;
    in_rs2   = v.rs2;
    while (!acc && n < 40) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        acc = 1;
        expq.push_back(v);
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout: instr 0x%08h never accepted", v.instr);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || out_valid || in_valid) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (n >= 60) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries still expected", expq.size());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got srca 0x%08h cntl %b with nothing expected",
                 out_srca, out_cntl);
      end else begin
        vec_t e;
        logic [73:0] got;
        e   = expq.pop_front();
        got = {out_srca, out_srcb, out_cntl, out_not_s, out_is_branch, out_br_f3, out_illegal};
        if (got !== e.exp) begin
          errors++;
          $display("FAIL decode instr 0x%08h: got %h expected %h", e.instr, got, e.exp);
        end
      end
    end
    if (flush) expq.delete();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    add(r_op(7'h00, 3'b000), 32'd5,        32'd7, mk(32'd5,        32'd7, 4'b0000, 1, 0, 3'b000, 0));
    add(r_op(7'h20, 3'b000), 32'd10,       32'd3, mk(32'd10,       32'd3, 4'b1000, 1, 0, 3'b000, 0));
    add(r_op(7'h00, 3'b001), 32'd1,        32'd4, mk(32'd1,        32'd4, 4'b0110, 1, 0, 3'b000, 0));
    add(r_op(7'h00, 3'b010), 32'hFFFFFFFF, 32'd1, mk(32'hFFFFFFFF, 32'd1, 4'b0001, 1, 0, 3'b000, 0));
    add(r_op(7'h00, 3'b011), 32'd2,        32'd3, mk(32'd2,        32'd3, 4'b0010, 0, 0, 3'b000, 0));
    add(r_op(7'h00, 3'b100), 32'hA5A5A5A5, 32'h0F0F0F0F,
        mk(32'hA5A5A5A5, 32'h0F0F0F0F, 4'b0101, 1, 0, 3'b000, 0));
    add(r_op(7'h00, 3'b101), 32'h80000000, 32'd4, mk(32'h80000000, 32'd4, 4'b0111, 1, 0, 3'b000, 0));
    add(r_op(7'h20, 3'b101), 32'h80000000, 32'd4, mk(32'h80000000, 32'd4, 4'b1001, 1, 0, 3'b000, 0));
    add(r_op(7'h00, 3'b110), 32'd12,       32'd3, mk(32'd12,       32'd3, 4'b0100, 1, 0, 3'b000, 0));
    add(r_op(7'h00, 3'b111), 32'd12,       32'd6, mk(32'd12,       32'd6, 4'b0011, 1, 0, 3'b000, 0));
    add(i_op(12'hFFF, 3'b000), 32'd1,      32'd99, mk(32'd1, 32'hFFFFFFFF, 4'b0000, 1, 0, 3'b000, 0));
    add(i_op(12'h403, 3'b101), 32'h80000000, 32'd99,
        mk(32'h80000000, 32'h00000403, 4'b1001, 1, 0, 3'b000, 0));
    add(i_op(12'h400, 3'b000), 32'd8,      32'd99, mk(32'd8, 32'h00000400, 4'b0000, 1, 0, 3'b000, 0));
    add(i_op(12'h005, 3'b011), 32'd9,      32'd99, mk(32'd9, 32'd5,        4'b0010, 0, 0, 3'b000, 0));
    add(b_op(3'b110), 32'd1,  32'd2,  mk(32'd1,  32'd2,  4'b0010, 0, 1, 3'b110, 0));
    add(b_op(3'b000), 32'd4,  32'd4,  mk(32'd4,  32'd4,  4'b1000, 1, 1, 3'b000, 0));
    add(b_op(3'b101), 32'd3,  32'd8,  mk(32'd3,  32'd8,  4'b0001, 1, 1, 3'b101, 0));
    add(b_op(3'b111), 32'd3,  32'd8,  mk(32'd3,  32'd8,  4'b0010, 0, 1, 3'b111, 0));
    add(b_op(3'b010), 32'd3,  32'd8,  mk(32'd0,  32'd0,  4'b0000, 1, 0, 3'b000, 1));
    add(c0_op(3'b000), 32'd6, 32'd9,  mk(32'd6,  32'd9,  4'b1010, 1, 0, 3'b000, 0));
    add(c0_op(3'b001), 32'd6, 32'd9,  mk(32'd0,  32'd0,  4'b0000, 1, 0, 3'b000, 1));
    add(32'hFFFFFFFF, 32'd123, 32'd456, mk(32'd0, 32'd0, 4'b0000, 1, 0, 3'b000, 1));

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_rs1 = '0; in_rs2 = '0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_srca",      out_srca, 32'd0);
    check("rst_srcb",      out_srcb, 32'd0);
    check("rst_cntl",      {28'd0, out_cntl}, 32'd0);
    check("rst_not_s",     {31'd0, out_not_s}, 32'd1);
    check("rst_flags",     {27'd0, out_is_branch, out_br_f3, out_illegal}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Stream all vectors with no backpressure; the first also checks latency 1.
    out_ready = 1'b1;
    send(vecs[0]);
    check("latency1_out_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 1; i < vecs.size(); i++) send(vecs[i]);
    drain();

    // Backpressure: two accepted, third held until the consumer resumes.
    out_ready = 1'b0;
    send(vecs[0]);
    send(vecs[14]);
    fork
      send(vecs[11]);
    join_none
    repeat (3) @(negedge clk);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_out_valid", {31'd0, out_valid}, 32'd1);
    check("full_held_srca", out_srca, 32'd5);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Flush while full.
    out_ready = 1'b0;
    send(vecs[1]);
    send(vecs[2]);
    @(negedge clk);
    check("flush_pre_full", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready",  {31'd0, in_ready},  32'd1);

    // Flush at count 1 with a simultaneous input offer: the input is dropped.
    send(vecs[3]);
    in_valid = 1'b1; in_instr = vecs[4].instr; in_rs1 = vecs[4].rs1; in_rs2 = vecs[4].rs2;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_blocks_input", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset with two entries buffered.
    @(posedge clk); #1;
    send(vecs[5]);
    send(vecs[6]);
    #2;
    rst_n = 1'b0;
    #1;
    expq.delete();
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready",  {31'd0, in_ready},  32'd1);
    check("arst_srca",      out_srca, 32'd0);
    check("arst_cntl_nots", {27'd0, out_cntl, out_not_s}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(vecs[13]);
    send(vecs[19]);
    drain();

    check("leftover_expected", expq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, rising edge.
REQ-002 SHALL have: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have: flush  input  1  discard all buffered and incoming entries.
REQ-004 SHALL have: in_valid  input  1  upstream entry valid.
REQ-005 SHALL have: in_ready  output  1  upstream may transfer.
REQ-006 SHALL have: in_instr  input  32  RV32 instruction word.
REQ-007 SHALL have: in_rs1 / in_rs2  input  32 each  register operands.
REQ-008 SHALL have: out_valid  output  1; out_ready  input  1.
REQ-009 SHALL have: out_srca / out_srcb  output  32 each  ALU operands.
REQ-010 SHALL have: out_cntl  output  4  ALU control code; out_not_s  output  1  ALU sign-use flag.
REQ-011 SHALL have: out_is_branch  output  1; out_br_f3  output  3  branch funct3; out_illegal  output  1.

Function
REQ-012 Transfer in when in_valid&&in_ready; transfer out when out_valid&&out_ready.
REQ-013 Decoded entry SHALL appear on outputs the cycle after input transfer (latency 1), all outputs registered.
REQ-014 Buffer SHALL be 2-entry skid: in_ready = not full (count<2), registered; count 0/1/2.
REQ-015 Simultaneous in/out transfer at count 1 SHALL keep count 1, order preserved; at count 2 no input transfer possible.
REQ-016 out_valid SHALL equal count!=0; outputs hold stable while out_valid&&!out_ready.
REQ-017 Opcode 0110011 (OP): srcb=in_rs2; funct3 000 ADD (SUB if instr[30]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if instr[30]), 110 OR, 111 AND.
REQ-018 Opcode 0010011 (OP-IMM): srcb = sign-extended instr[31:20]; same funct3 map; instr[30] selects SRA only for funct3 101, never SUB.
REQ-019 Opcode 1100011 (BRANCH): srcb=in_rs2, out_is_branch=1, out_br_f3=funct3; BEQ/BNE->SUB, BLT/BGE->SLT, BLTU/BGEU->SLTU; funct3 010/011 illegal.
REQ-020 Opcode 0001011 funct3 000 (custom-0): cntl=AM, srcb=in_rs2.
REQ-021 Control codes: ADD 0000, SLT 0001, SLTU 0010, AND 0011, OR 0100, XOR 0101, SLL 0110, SRL 0111, SUB 1000, SRA 1001, AM 1010.
REQ-022 out_not_s SHALL be 0 for SLTU class (SLTU, SLTIU, BLTU, BGEU), 1 otherwise.
REQ-023 out_srca SHALL equal in_rs1 for every legal entry.
REQ-024 Any other encoding: out_illegal=1, cntl=ADD, srca=srcb=0, is_branch=0, not_s=1; entry still flows through buffer.
REQ-025 flush SHALL set count to 0 at next edge and block input transfer that cycle; output transfer in flush cycle is permitted.

Reset
REQ-026 rst_n low SHALL asynchronously clear count to 0: out_valid=0, in_ready=1.
REQ-027 Under reset data outputs SHALL read 0, out_cntl=ADD, out_not_s=1, flags 0.
REQ-028 Reset mid-transfer SHALL drop all entries; first post-reset entry decoded normally.

Structure
REQ-029 Control-code localparams and opcode constants SHALL live in shared package cpu_pkg, also used by alu.
REQ-030 Decode logic SHALL be sub-module alu_issue_dec (combinational); buffer/handshake in alu_issue.

Verification
REQ-031 ADD x, rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, cntl=0000, srca=5, srcb=7, not_s=1.
REQ-032 ADDI imm=0xFFF, rs1=1 -> srcb=0xFFFFFFFF, cntl=ADD; SRAI imm=0x403 -> cntl=1001, srcb=0x403.
REQ-033 BLTU rs1=1, rs2=2 -> is_branch=1, br_f3=110, cntl=0010, not_s=0.
REQ-034 out_ready=0, three back-to-back inputs -> two accepted, in_ready=0, third held; release -> three outputs in order.
REQ-035 Word 0xFFFFFFFF -> out_illegal=1, cntl=0000, operands 0.
REQ-036 Count 2, assert flush one cycle -> out_valid=0, in_ready=1 next cycle; rst_n low mid-stream -> out_valid=0 immediately.
